// File: rtl/ifm_scan_ctrl.sv
// ifm_scan_ctrl: serpentine scan sequencer for the 3x3 IFM window buffer.
// Fetches pixel triplets over req/ack, drives the buffer command word, and
// hands complete windows to the PE array over a valid/ready handshake.
// Ports: clk, rst (async, active-high), start, busy, done;
//   fetch_req/fetch_vert/fetch_row/fetch_col out, fetch_ack/fetch_data in;
//   buf_rst_n/buf_valid/buf_word out; win_valid/win_row/win_col out, win_ready in.
// Optional: IFM_SCAN_PERF_EN adds perf_cycles and perf_stalls counters.
module ifm_scan_ctrl #(
    parameter int IFM_W   = 8,
    parameter int IFM_H   = 8,
    parameter int COORD_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               fetch_req,
    output logic               fetch_vert,
    output logic [COORD_W-1:0] fetch_row,
    output logic [COORD_W-1:0] fetch_col,
    input  logic               fetch_ack,
    input  logic [23:0]        fetch_data,
    output logic               buf_rst_n,
    output logic               buf_valid,
    output logic [31:0]        buf_word,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col
`ifdef IFM_SCAN_PERF_EN
    ,
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_stalls
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_EMIT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [7:0] HDR_ALL   = 8'h00;
    localparam logic [7:0] HDR_RIGHT = 8'h01;
    localparam logic [7:0] HDR_LEFT  = 8'h02;
    localparam logic [7:0] HDR_DOWN  = 8'hFF;

    localparam logic [COORD_W-1:0] LAST_C = COORD_W'(IFM_W - 3);
    localparam logic [COORD_W-1:0] LAST_R = COORD_W'(IFM_H - 3);

    logic [2:0]         state;
    logic [2:0]         state_d;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic               dir;
    logic [1:0]         load_cnt;
    logic [7:0]         hdr;
    logic [23:0]        data;
    logic               buf_rst_q;
    logic               row_end;
    logic               last_win;
    logic               more_all;

    // row/col always hold the origin of the window the current step builds,
    // so fetch coordinates are derived from the new origin and the header.
    assign row_end  = dir ? (col == LAST_C) : (col == '0);
    assign last_win = row_end && (row == LAST_R);
    assign more_all = (hdr == HDR_ALL) && (load_cnt != 2'd2);

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:  if (start) state_d = S_CLR;
            S_CLR:   state_d = S_FETCH;
            S_FETCH: if (fetch_ack) state_d = S_WRITE;
            S_WRITE: state_d = more_all ? S_FETCH : S_EMIT;
            S_EMIT:  if (win_ready) state_d = last_win ? S_DONE : S_FETCH;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            row       <= '0;
            col       <= '0;
            dir       <= 1'b0;
            load_cnt  <= 2'd0;
            hdr       <= HDR_ALL;
            data      <= '0;
            buf_rst_q <= 1'b0;
        end else begin
            state     <= state_d;
            // Buffer reset is low only while sitting in CLR.
            buf_rst_q <= (state_d != S_CLR);
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        row      <= '0;
                        col      <= '0;
                        dir      <= 1'b1;
                        load_cnt <= 2'd0;
                        hdr      <= HDR_ALL;
                    end
                end
                S_FETCH: begin
                    if (fetch_ack) data <= fetch_data;
                end
                S_WRITE: begin
                    if (more_all) load_cnt <= load_cnt + 2'd1;
                end
                S_EMIT: begin
                    if (win_ready && !last_win) begin
                        if (row_end) begin
                            hdr <= HDR_DOWN;
                            row <= row + COORD_W'(1);
                            dir <= !dir;
                        end else if (dir) begin
                            hdr <= HDR_RIGHT;
                            col <= col + COORD_W'(1);
                        end else begin
                            hdr <= HDR_LEFT;
                            col <= col - COORD_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = (state == S_CLR) || (state == S_FETCH) ||
                        (state == S_WRITE) || (state == S_EMIT);
    assign done       = (state == S_DONE);
    assign fetch_req  = (state == S_FETCH);
    assign fetch_vert = fetch_req && (hdr != HDR_DOWN);
    assign buf_rst_n  = buf_rst_q;
    assign buf_valid  = (state == S_WRITE);
    assign buf_word   = buf_valid ? {hdr, data} : 32'd0;
    assign win_valid  = (state == S_EMIT);
    assign win_row    = win_valid ? row : '0;
    assign win_col    = win_valid ? col : '0;

    // DOWN brings in the new bottom row; RIGHT the new right column;
    // LEFT the new left column; ALL loads columns 0..2 of row 0.
    always_comb begin
        fetch_row = '0;
        fetch_col = '0;
        if (fetch_req) begin
            fetch_row = (hdr == HDR_DOWN) ? row + COORD_W'(2) : row;
            if (hdr == HDR_ALL)
                fetch_col = COORD_W'(load_cnt);
            else if (hdr == HDR_RIGHT)
                fetch_col = col + COORD_W'(2);
            else
                fetch_col = col;
        end
    end

`ifdef IFM_SCAN_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (state == S_IDLE && start) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (busy) begin
            perf_cycles <= perf_cycles + 32'd1;
            if ((fetch_req && !fetch_ack) || (win_valid && !win_ready))
                perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifm_scan_ctrl.sv
// tb_ifm_scan_ctrl: directed, table-driven bench for ifm_scan_ctrl.
// Runs 5x5 frames against a pixel model plus 3x3 and 3x6 boundary maps.
module tb_ifm_scan_ctrl;

    typedef struct {
        int ack_dly;
        int stall_win;
        int stall_len;
        bit chk_lat;
    } frm_t;

    typedef struct {
        logic [7:0] row;
        logic [7:0] col;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 5x5 instance
    logic        start = 1'b0;
    logic        busy, done, fetch_req, fetch_vert;
    logic [7:0]  fetch_row, fetch_col;
    logic        fetch_ack = 1'b0;
    logic [23:0] fetch_data;
    logic        buf_rst_n, buf_valid;
    logic [31:0] buf_word;
    logic        win_valid;
    logic        win_ready = 1'b0;
    logic [7:0]  win_row, win_col;

    // 3x3 instance
    logic        s3_start = 1'b0;
    logic        s3_busy, s3_done, s3_req, s3_vert;
    logic [7:0]  s3_frow, s3_fcol;
    logic        s3_brst, s3_bv;
    logic [31:0] s3_bw;
    logic        s3_wv;
    logic [7:0]  s3_wr, s3_wc;

    // 3x6 instance
    logic        t_start = 1'b0;
    logic        t_busy, t_done, t_req, t_vert;
    logic [7:0]  t_frow, t_fcol;
    logic        t_brst, t_bv;
    logic [31:0] t_bw;
    logic        t_wv;
    logic [7:0]  t_wr, t_wc;

    function automatic logic [7:0] px(input logic [7:0] r, input logic [7:0] c);
        return {r[3:0], c[3:0]};
    endfunction

    // Pixel(r,c) = r*16 + c
    assign fetch_data = fetch_vert ?
        {px(fetch_row, fetch_col), px(8'(fetch_row + 1), fetch_col),
         px(8'(fetch_row + 2), fetch_col)} :
        {px(fetch_row, fetch_col), px(fetch_row, 8'(fetch_col + 1)),
         px(fetch_row, 8'(fetch_col + 2))};

    ifm_scan_ctrl #(.IFM_W(5), .IFM_H(5), .COORD_W(8)) u5 (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .fetch_req(fetch_req), .fetch_vert(fetch_vert),
        .fetch_row(fetch_row), .fetch_col(fetch_col),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .buf_rst_n(buf_rst_n), .buf_valid(buf_valid), .buf_word(buf_word),
        .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col)
    );

    ifm_scan_ctrl #(.IFM_W(3), .IFM_H(3), .COORD_W(8)) u3 (
        .clk(clk), .rst(rst), .start(s3_start), .busy(s3_busy), .done(s3_done),
        .fetch_req(s3_req), .fetch_vert(s3_vert),
        .fetch_row(s3_frow), .fetch_col(s3_fcol),
        .fetch_ack(1'b1), .fetch_data(24'h0),
        .buf_rst_n(s3_brst), .buf_valid(s3_bv), .buf_word(s3_bw),
        .win_valid(s3_wv), .win_ready(1'b1),
        .win_row(s3_wr), .win_col(s3_wc)
    );

    ifm_scan_ctrl #(.IFM_W(6), .IFM_H(3), .COORD_W(8)) u36 (
        .clk(clk), .rst(rst), .start(t_start), .busy(t_busy), .done(t_done),
        .fetch_req(t_req), .fetch_vert(t_vert),
        .fetch_row(t_frow), .fetch_col(t_fcol),
        .fetch_ack(1'b1), .fetch_data(24'h0),
        .buf_rst_n(t_brst), .buf_valid(t_bv), .buf_word(t_bw),
        .win_valid(t_wv), .win_ready(1'b1),
        .win_row(t_wr), .win_col(t_wc)
    );

    int n_pass = 0;
    int n_tot  = 0;

    logic [31:0] cmds[11];
    win_t        wins[9];
    frm_t        frames[3];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, {25'd0, busy, done, fetch_req, fetch_vert,
                           buf_rst_n, buf_valid, win_valid}, 32'd0);
        chk({nm, "_crd"}, {fetch_row, fetch_col, win_row, win_col}, 32'd0);
        chk({nm, "_word"}, buf_word, 32'd0);
    endtask

    task automatic run_frame(input frm_t f);
        int ci, wi, wa, ws, last_w, rst_lo;
        logic [7:0] fr, fc;
        bit fin;
        ci = 0; wi = 0; wa = 0; ws = 0; last_w = 0; rst_lo = 0; fin = 0;
        fr = '0; fc = '0;
        fetch_ack = (f.ack_dly == 0);
        win_ready = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (cyc == 0) chk("busy_in_clr", busy, 1);
            if (!buf_rst_n) rst_lo++;
            start = 1'b0;
            if (fetch_req && f.ack_dly > 0) begin
                if (wa == 0) begin
                    fr = fetch_row;
                    fc = fetch_col;
                end else begin
                    chk("fetch_row_hold", fetch_row, fr);
                    chk("fetch_col_hold", fetch_col, fc);
                    chk("fetch_req_hold", fetch_req, 1);
                end
                if (wa == 1) start = 1'b1;
                fetch_ack = (wa == f.ack_dly);
                wa = (wa == f.ack_dly) ? 0 : wa + 1;
            end else if (f.ack_dly > 0) begin
                fetch_ack = 1'b0;
            end
            if (buf_valid) begin
                if (ci < 11) chk("buf_word", buf_word, cmds[ci]);
                else chk("extra_cmd", ci, 11);
                ci++;
            end
            if (win_valid) begin
                if (wi >= 9) begin
                    chk("extra_win", wi, 9);
                end else if (ws == 0) begin
                    chk("win_row", win_row, wins[wi].row);
                    chk("win_col", win_col, wins[wi].col);
                    if (f.chk_lat && wi == 0) chk("first_latency", cyc, 7);
                    if (f.chk_lat && wi > 0) chk("win_spacing", cyc - last_w, 3);
                    last_w = cyc;
                end else begin
                    chk("stall_valid", win_valid, 1);
                    chk("stall_row", win_row, wins[wi].row);
                    chk("stall_col", win_col, wins[wi].col);
                    chk("stall_bufv", buf_valid, 0);
                end
                if (wi == f.stall_win && ws < f.stall_len) begin
                    win_ready = 1'b0;
                    ws++;
                end else begin
                    win_ready = 1'b1;
                    ws = 0;
                    wi++;
                end
            end
            if (done) begin
                chk("done_busy_low", busy, 0);
                chk("n_cmds", ci, 11);
                chk("n_wins", wi, 9);
                chk("buf_rst_low_cycles", rst_lo, 1);
                fin = 1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!fin) chk("frame_timeout", 0, 1);
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        int n3f, n3w, n3d, ntf, ntw, ntd, nt_right, nt_bad;

        cmds[0]  = 32'h00_00_10_20;
        cmds[1]  = 32'h00_01_11_21;
        cmds[2]  = 32'h00_02_12_22;
        cmds[3]  = 32'h01_03_13_23;
        cmds[4]  = 32'h01_04_14_24;
        cmds[5]  = 32'hFF_32_33_34;
        cmds[6]  = 32'h02_11_21_31;
        cmds[7]  = 32'h02_10_20_30;
        cmds[8]  = 32'hFF_40_41_42;
        cmds[9]  = 32'h01_23_33_43;
        cmds[10] = 32'h01_24_34_44;
        wins[0] = '{8'd0, 8'd0};
        wins[1] = '{8'd0, 8'd1};
        wins[2] = '{8'd0, 8'd2};
        wins[3] = '{8'd1, 8'd2};
        wins[4] = '{8'd1, 8'd1};
        wins[5] = '{8'd1, 8'd0};
        wins[6] = '{8'd2, 8'd0};
        wins[7] = '{8'd2, 8'd1};
        wins[8] = '{8'd2, 8'd2};
        frames[0] = '{0, -1, 0, 1'b1};
        frames[1] = '{3, -1, 0, 1'b0};
        frames[2] = '{0, 4, 5, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("buf_rst_release", buf_rst_n, 1);
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 3; i++) begin
            run_frame(frames[i]);
            repeat (2) @(negedge clk);
        end

        // Reset in the middle of the first row
        fetch_ack = 1'b1;
        win_ready = 1'b1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 60 && !(win_valid && win_col == 8'd1); i++)
            @(negedge clk);
        chk("midrow_reached", {31'd0, win_valid}, 1);
        rst = 1'b1;
        #1;
        chk_zero("rst_async");
        @(negedge clk);
        chk_zero("rst_held");
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_bufn", buf_rst_n, 1);
        chk("rst_rel_idle", busy, 0);
        run_frame(frames[0]);

        // 3x3 and 3x6 boundary maps, ack/ready tied high
        n3f = 0; n3w = 0; n3d = 0;
        ntf = 0; ntw = 0; ntd = 0; nt_right = 0; nt_bad = 0;
        @(negedge clk);
        s3_start = 1'b1;
        t_start  = 1'b1;
        @(negedge clk);
        s3_start = 1'b0;
        t_start  = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (s3_req) n3f++;
            if (s3_wv) begin
                chk("w3_coord", {s3_wr, s3_wc}, 16'h0000);
                n3w++;
            end
            if (s3_done) n3d++;
            if (t_req) ntf++;
            if (t_wv) begin
                chk("w36_row", t_wr, 0);
                chk("w36_col", t_wc, ntw);
                ntw++;
            end
            if (t_bv) begin
                if (t_bw[31:24] == 8'h01) nt_right++;
                else if (t_bw[31:24] != 8'h00) nt_bad++;
            end
            if (t_done) ntd++;
            @(negedge clk);
        end
        chk("m3_fetches", n3f, 3);
        chk("m3_windows", n3w, 1);
        chk("m3_done", n3d, 1);
        chk("m36_fetches", ntf, 6);
        chk("m36_windows", ntw, 4);
        chk("m36_right", nt_right, 3);
        chk("m36_no_down_left", nt_bad, 0);
        chk("m36_done", ntd, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
